// File: rtl/inst_queue_mw_pkg.sv
// Shared defaults and entry layout helpers for the multi-width instruction queue.
// Entries are packed as {shared, info, inst, pc}, so ID can slice fields with the same offsets.
package inst_queue_mw_pkg;
    localparam int IQ_FETCH_W     = 4;
    localparam int IQ_ISSUE_W     = 2;
    localparam int IQ_DEPTH       = 16;
    localparam int IQ_INFO_W      = 40;
    localparam int IQ_SHARED_W    = 7;
    localparam int IQ_STOP_MARGIN = 8;

    localparam int IQ_PC_LSB   = 0;
    localparam int IQ_INST_LSB = 32;
    localparam int IQ_INFO_LSB = 64;

    function automatic int iq_entry_w(input int info_w, input int shared_w);
        return shared_w + info_w + 64;
    endfunction
endpackage

// File: rtl/inst_queue_mw_slot_count.sv
// Counts enabled fetch slots and flags enables that are not a thermometer code.
module iq_slot_count #(
    parameter int FETCH_W = 4,
    parameter int CW      = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0] en,
    output logic [CW-1:0]      cnt,
    output logic               thermo_ok
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < FETCH_W; i++) cnt = cnt + CW'(en[i]);
    end

    // A thermometer code plus one has no bits in common with itself.
    assign thermo_ok = ((en & (en + FETCH_W'(1))) == '0);
endmodule

// File: rtl/inst_queue_mw.sv
// Multi-width instruction queue between IF and ID: FETCH_W in per packet, oldest ISSUE_W presented.
// Occupancy is tail-head on wrap-bit pointers, so a completely full queue is distinct from empty.
module inst_queue_mw
    import inst_queue_mw_pkg::*;
#(
    parameter int FETCH_W     = IQ_FETCH_W,
    parameter int ISSUE_W     = IQ_ISSUE_W,
    parameter int DEPTH       = IQ_DEPTH,
    parameter int INFO_W      = IQ_INFO_W,
    parameter int SHARED_W    = IQ_SHARED_W,
    parameter int STOP_MARGIN = IQ_STOP_MARGIN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FETCH_W-1:0]           in_enable_i,
    input  logic [31:0]                  in_base_pc_i,
    input  logic [FETCH_W*32-1:0]        in_inst_i,
    input  logic [FETCH_W*INFO_W-1:0]    in_info_i,
    input  logic [SHARED_W-1:0]          in_shared_i,
    output logic [ISSUE_W-1:0]           out_valid_o,
    output logic [ISSUE_W*32-1:0]        out_pc_o,
    output logic [ISSUE_W*32-1:0]        out_inst_o,
    output logic [ISSUE_W*INFO_W-1:0]    out_info_o,
    output logic [ISSUE_W*SHARED_W-1:0]  out_shared_o,
    input  logic [$clog2(ISSUE_W+1)-1:0] deq_num_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         stop_fetch_o,
    output logic                         err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int L  = $clog2(FETCH_W);
    localparam int CW = $clog2(FETCH_W + 1);
    localparam int EW = iq_entry_w(INFO_W, SHARED_W);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] STOP_C  = PW'(DEPTH - STOP_MARGIN);

    logic [PW-1:0] head, tail, count, enq_add, deq_w, deq_eff;
    logic [CW-1:0] enq_n;
    logic          thermo_ok, enq_fire, deq_over;
    logic [EW-1:0] mem [DEPTH];
    logic [FETCH_W-1:0][EW-1:0] wr_ent;

    iq_slot_count #(.FETCH_W(FETCH_W), .CW(CW)) u_slot_count (
        .en       (in_enable_i),
        .cnt      (enq_n),
        .thermo_ok(thermo_ok)
    );

    assign count      = tail - head;
    assign in_ready_o = (DEPTH_C - count) >= PW'(FETCH_W);
    assign enq_fire   = in_valid_i & in_ready_o;
    assign enq_add    = enq_fire ? PW'(enq_n) : '0;
    assign deq_w      = PW'(deq_num_i);
    assign deq_over   = deq_w > count;
    assign deq_eff    = deq_over ? count : deq_w;

    // Slot PCs stay inside the aligned FETCH_W-word block of the base PC.
    for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
        logic [L-1:0] ofs;
        assign ofs       = in_base_pc_i[L+1:2] + L'(i);
        assign wr_ent[i] = {in_shared_i, in_info_i[i*INFO_W +: INFO_W], in_inst_i[i*32 +: 32],
                            in_base_pc_i[31:L+2], ofs, in_base_pc_i[1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            err_o <= 1'b0;
        end else begin
            if (flush_i) begin
                head <= '0;
                tail <= '0;
            end else begin
                head <= head + deq_eff;
                tail <= tail + enq_add;
            end
            if ((enq_fire & ~thermo_ok) | deq_over) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush_i) begin
            for (int i = 0; i < FETCH_W; i++)
                if (CW'(i) < enq_n) mem[tail[AW-1:0] + AW'(i)] <= wr_ent[i];
        end
    end

    for (genvar j = 0; j < ISSUE_W; j++) begin : g_out
        logic [EW-1:0] rd;
        assign rd                                  = mem[head[AW-1:0] + AW'(j)];
        assign out_valid_o[j]                      = count > PW'(j);
        assign out_pc_o[j*32 +: 32]                = rd[IQ_PC_LSB +: 32];
        assign out_inst_o[j*32 +: 32]              = rd[IQ_INST_LSB +: 32];
        assign out_info_o[j*INFO_W +: INFO_W]      = rd[IQ_INFO_LSB +: INFO_W];
        assign out_shared_o[j*SHARED_W +: SHARED_W] = rd[IQ_INFO_LSB+INFO_W +: SHARED_W];
    end

    assign count_o      = count;
    assign empty_o      = (count == '0);
    assign full_o       = (count == DEPTH_C);
    assign stop_fetch_o = (count >= STOP_C) & ~flush_i;
endmodule
